// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - operand queue and beg/ack handshake sequencer for an FPU function unit
//
// Purpose: buffers operand pairs plus rounding mode in a DEPTH-entry queue and
// issues them one at a time to an FPU using the beg_FSM / ack_FSM / ready
// handshake. Each result is captured with its flags and the measured latency
// and is offered on a valid/ready result port.
//
// Optional feature macro: FPU_SEQ_TIMEOUT_EN. When defined, an operation still
// waiting after TIMEOUT cycles is aborted with a zero result and flags 3'b100.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        operand push handshake
//   in_x, in_y, in_rmode     operands and rounding mode
//   fpu_beg, fpu_ack         start pulse and result acknowledge to the FPU
//   fpu_x, fpu_y, fpu_rmode  registered operands to the FPU
//   fpu_ready                FPU result valid
//   fpu_result, fpu_ovf/unf  FPU result and flags
//   res_valid/res_ready      result handshake
//   res_data, res_flags      captured result, {timeout, underflow, overflow}
//   res_latency              cycles from beg to ready
//   busy                     FSM active or queue non-empty
//   op_count                 completed operations, wraps

module fpu_op_sequencer #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [1:0]       in_rmode,
  output logic             fpu_beg,
  output logic             fpu_ack,
  output logic [W-1:0]     fpu_x,
  output logic [W-1:0]     fpu_y,
  output logic [1:0]       fpu_rmode,
  input  logic             fpu_ready,
  input  logic [W-1:0]     fpu_result,
  input  logic             fpu_ovf,
  input  logic             fpu_unf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [2:0]       res_flags,
  output logic [CNT_W-1:0] res_latency,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK,
    S_OUT
  } state_t;

  state_t state_q;

  // Operand queue storage; emptiness is defined by the pointers and count,
  // so the storage itself needs no reset.
  logic [W-1:0] qx_q [DEPTH];
  logic [W-1:0] qy_q [DEPTH];
  logic [1:0]   qr_q [DEPTH];

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  logic             fpu_beg_q;
  logic             fpu_ack_q;
  logic [W-1:0]     fpu_x_q;
  logic [W-1:0]     fpu_y_q;
  logic [1:0]       fpu_rmode_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] lat_d;
  logic             res_valid_q;
  logic [W-1:0]     res_data_q;
  logic             res_ovf_q;
  logic             res_unf_q;
  logic [CNT_W-1:0] res_lat_q;
  logic [15:0]      op_count_q;

  logic push;
  logic pop;

  assign in_ready = (cnt_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Saturating increment; the same value is what gets reported as latency,
  // so a ready seen in the first WAIT cycle reports 1.
  assign lat_d = (&lat_q) ? lat_q : lat_q + 1'b1;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_VAL = TIMEOUT[CNT_W-1:0];
  logic res_to_q;
  logic timeout_hit;
  assign timeout_hit = (lat_d == TO_VAL);
  assign res_flags   = {res_to_q, res_unf_q, res_ovf_q};
`else
  assign res_flags   = {1'b0, res_unf_q, res_ovf_q};
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      qx_q[wr_ptr_q] <= in_x;
      qy_q[wr_ptr_q] <= in_y;
      qr_q[wr_ptr_q] <= in_rmode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      fpu_beg_q   <= 1'b0;
      fpu_ack_q   <= 1'b0;
      fpu_x_q     <= '0;
      fpu_y_q     <= '0;
      fpu_rmode_q <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_unf_q   <= 1'b0;
      res_lat_q   <= '0;
      op_count_q  <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
      res_to_q    <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            fpu_x_q     <= qx_q[rd_ptr_q];
            fpu_y_q     <= qy_q[rd_ptr_q];
            fpu_rmode_q <= qr_q[rd_ptr_q];
            fpu_beg_q   <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          fpu_beg_q <= 1'b0;
          lat_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          lat_q <= lat_d;
          if (fpu_ready) begin
            res_data_q <= fpu_result;
            res_ovf_q  <= fpu_ovf;
            res_unf_q  <= fpu_unf;
            res_lat_q  <= lat_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            res_to_q   <= 1'b0;
`endif
            fpu_ack_q  <= 1'b1;
            state_q    <= S_ACK;
`ifdef FPU_SEQ_TIMEOUT_EN
          end else if (timeout_hit) begin
            // A single ack pulse forces the FPU FSM to release the op.
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_unf_q  <= 1'b0;
            res_lat_q  <= TO_VAL;
            res_to_q   <= 1'b1;
            fpu_ack_q  <= 1'b1;
            state_q    <= S_ACK;
`endif
          end
        end
        S_ACK: begin
          // Keep acknowledging while the FPU still holds ready high.
          if (!fpu_ready) begin
            fpu_ack_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fpu_beg     = fpu_beg_q;
  assign fpu_ack     = fpu_ack_q;
  assign fpu_x       = fpu_x_q;
  assign fpu_y       = fpu_y_q;
  assign fpu_rmode   = fpu_rmode_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_latency = res_lat_q;
  assign busy        = (state_q != S_IDLE) || (cnt_q != '0);
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - self-checking bench for fpu_op_sequencer
module tb_fpu_op_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TB_TO = 50;
`else
  localparam int TB_TO = 1023;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic [1:0]       in_rmode;
  logic             fpu_beg;
  logic             fpu_ack;
  logic [W-1:0]     fpu_x;
  logic [W-1:0]     fpu_y;
  logic [1:0]       fpu_rmode;
  logic             fpu_ready;
  logic [W-1:0]     fpu_result;
  logic             fpu_ovf;
  logic             fpu_unf;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;
  logic [2:0]       res_flags;
  logic [CNT_W-1:0] res_latency;
  logic             busy;
  logic [15:0]      op_count;

  fpu_op_sequencer #(
    .W(W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TB_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_rmode(in_rmode),
    .fpu_beg(fpu_beg), .fpu_ack(fpu_ack),
    .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_rmode(fpu_rmode),
    .fpu_ready(fpu_ready), .fpu_result(fpu_result),
    .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .res_latency(res_latency),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Per-operation FPU behaviour, indexed by issue order: ready appears d
  // cycles after beg (0 = never) and stays high for h cycles.
  int          cfg_d   [12] = '{5, 30, 2, 3, 1, 4, 3, 2, 2, 0, 0, 0};
  int          cfg_h   [12] = '{1, 1, 1, 2, 1, 1, 1, 1, 4, 1, 1, 1};
  logic [31:0] cfg_res [12] = '{32'h40000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
                                32'h7F800000, 32'h0, 32'h0, 32'h0};
  bit          cfg_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  bit          cfg_unf [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  // FPU behavioural model
  initial begin : fpu_model
    bit r;
    bit act;
    int k, dd, hh, di, ndrv;
    act = 0; k = 0; dd = 0; hh = 0; di = 0; ndrv = 0;
    fpu_ready = 1'b0; fpu_result = '0; fpu_ovf = 1'b0; fpu_unf = 1'b0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (!r) begin
        act = 0; fpu_ready = 1'b0; fpu_ovf = 1'b0; fpu_unf = 1'b0;
      end else if (act) begin
        k++;
        if (dd != 0 && k == dd) begin
          fpu_ready = 1'b1; fpu_result = cfg_res[di];
          fpu_ovf = cfg_ovf[di]; fpu_unf = cfg_unf[di];
        end
        if (dd != 0 && k == dd + hh) begin
          fpu_ready = 1'b0; fpu_ovf = 1'b0; fpu_unf = 1'b0; act = 0;
        end
        if (dd == 0 && fpu_ack) act = 0;
      end else if (fpu_beg) begin
        act = 1; k = 0; di = ndrv; ndrv++;
        dd = cfg_d[di]; hh = cfg_h[di];
      end
    end
  end

  // Reference model: ops flow through a queue; issue, ack and result timing
  // follow from the queue occupancy and the FPU profile of each op.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  rm;
  } op_t;

  op_t         mq[$];
  int          occ = 0;
  bit          m_idle = 1, beg_next = 0, inf = 0, mon_en = 0;
  int          mb = 0, md = 0, mh = 0, nbeg_m = 0;
  logic [15:0] completed = 0;
  logic [31:0] m_data = 0;
  logic [2:0]  m_flags = 0;
  logic [15:0] m_lat = 0;

  always @(negedge clk) begin : monitor
    op_t o;
    bit  e_ack, e_rv;
    if (mon_en) begin
      chk("fpu_beg", fpu_beg, beg_next);
      if (beg_next) begin
        chk("queue_nonempty_at_issue", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          o = mq.pop_front();
          chk("fpu_x", fpu_x, o.x);
          chk("fpu_y", fpu_y, o.y);
          chk("fpu_rmode", fpu_rmode, o.rm);
        end
        occ--; inf = 1; mb = cyc; m_idle = 0; beg_next = 0;
        md = cfg_d[nbeg_m]; mh = cfg_h[nbeg_m];
        m_data = cfg_res[nbeg_m];
        m_flags = {1'b0, cfg_unf[nbeg_m], cfg_ovf[nbeg_m]};
        m_lat = 16'(md);
`ifdef FPU_SEQ_TIMEOUT_EN
        if (md == 0) begin
          md = TB_TO; mh = 1; m_data = 0; m_flags = 3'b100; m_lat = 16'(TB_TO);
        end
`endif
        if (nbeg_m < 11) nbeg_m++;
      end
      e_ack = inf && md != 0 && cyc >= mb + md + 1 && cyc <= mb + md + mh;
      e_rv  = inf && md != 0 && cyc >= mb + md + mh + 1;
      chk("fpu_ack", fpu_ack, e_ack);
      chk("res_valid", res_valid, e_rv);
      if (e_rv) begin
        chk("res_data", res_data, m_data);
        chk("res_flags", res_flags, m_flags);
        chk("res_latency", res_latency, m_lat);
      end
      chk("beg_ack_exclusive", fpu_beg && fpu_ack, 0);
      chk("in_ready", in_ready, occ < DEPTH);
      chk("busy", busy, !m_idle || occ > 0);
      chk("op_count", op_count, completed);

      beg_next = m_idle && occ > 0;
      if (e_rv && res_ready) begin
        completed++; inf = 0; m_idle = 1;
      end
      if (rst && in_valid && occ < DEPTH) begin
        mq.push_back('{x: in_x, y: in_y, rm: in_rmode});
        occ++;
      end
      if (!rst) begin
        mq.delete(); occ = 0; m_idle = 1; beg_next = 0; inf = 0; completed = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
    in_valid = 1'b1; in_x = x; in_y = y; in_rmode = rm;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_rv(input int lim, output int acks);
    acks = 0;
    for (int i = 0; i < lim && !res_valid; i++) begin
      step(1);
      if (fpu_ack) acks++;
    end
    chk("wait_res_valid", res_valid, 1);
  endtask

  task automatic wait_ops(input logic [15:0] target, input int lim);
    for (int i = 0; i < lim && op_count != target; i++) step(1);
    chk("op_count_reached", op_count, target);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int acks;
    int n;
    int nb;
    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_rmode = '0; res_ready = 1'b1;
    step(3);
    rst = 1'b1;
    mon_en = 1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_fpu_beg", fpu_beg, 0);
    chk("reset_fpu_ack", fpu_ack, 0);
    chk("reset_busy", busy, 0);
    chk("reset_op_count", op_count, 0);

    // Single op: ready 5 cycles after beg
    push(32'h3F800000, 32'h40000000, 2'b00);
    wait_rv(50, acks);
    chk("single_data", res_data, 32'h40000000);
    chk("single_flags", res_flags, 3'b000);
    chk("single_latency", res_latency, 5);
    chk("single_acks", acks, 1);
    step(1);
    chk("single_op_count", op_count, 1);

    // Queue fill while the first op of the burst stalls
    for (int i = 0; i < 5; i++) push(32'h3F800010 + i, 32'h40000010 + i, 2'(i));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_x = 32'hDEADBEEF; in_y = 32'hDEADBEEF; in_rmode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("blocked_push_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    wait_ops(16'd6, 600);

    // Result backpressure for 20 cycles
    res_ready = 1'b0;
    push(32'h3F800020, 32'h40000020, 2'b10);
    push(32'h3F800021, 32'h40000021, 2'b01);
    wait_rv(50, acks);
    step(20);
    chk("bp_res_valid_held", res_valid, 1);
    chk("bp_res_data_held", res_data, 32'h66666666);
    res_ready = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (fpu_beg) begin
        n = i;
        break;
      end
    end
    chk("bp_next_beg_gap", n, 2);
    wait_ops(16'd8, 100);

    // Sticky ready with overflow
    push(32'h7F7FFFFF, 32'h40000000, 2'b01);
    wait_rv(50, acks);
    chk("sticky_flags", res_flags, 3'b001);
    chk("sticky_data", res_data, 32'h7F800000);
    chk("sticky_ack_cycles", acks, 4);
    step(1);
    chk("sticky_op_count", op_count, 9);

    // FPU never answers
    push(32'h3F800030, 32'h40000030, 2'b00);
`ifdef FPU_SEQ_TIMEOUT_EN
    wait_rv(200, acks);
    chk("timeout_flags", res_flags, 3'b100);
    chk("timeout_data", res_data, 0);
    chk("timeout_latency", res_latency, TB_TO);
    chk("timeout_acks", acks, 1);
    step(1);
    chk("timeout_op_count", op_count, 10);
    push(32'h3F800040, 32'h40000040, 2'b00);
    push(32'h3F800041, 32'h40000041, 2'b01);
    push(32'h3F800042, 32'h40000042, 2'b10);
`else
    step(2000);
    chk("stall_busy", busy, 1);
    chk("stall_res_valid", res_valid, 0);
    push(32'h3F800041, 32'h40000041, 2'b01);
    push(32'h3F800042, 32'h40000042, 2'b10);
`endif

    // Reset mid-WAIT with two entries queued
    step(5);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_in_ready", in_ready, 1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("midrst_fpu_beg", fpu_beg, 0);
    chk("midrst_fpu_ack", fpu_ack, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_busy", busy, 0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (fpu_beg) nb++;
    end
    chk("midrst_no_beg", nb, 0);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
